// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback controller.
// Holds the default widths and the requester identifiers.
package regfile_pkg;

    localparam int DATA_W_DFLT = 32;
    localparam int ADDR_W_DFLT = 5;
    localparam int NREG_DFLT   = 32;

    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    function automatic src_e other_src(input src_e s);
        return (s == SRC_ALU) ? SRC_MEM : SRC_ALU;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter for the ALU and load writeback ports.
// The priority flop names the requester that wins the next tie.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    src_e prio_q;
    src_e prio_d;

    always_comb begin
        gnt_o  = 2'b00;
        prio_d = prio_q;
        unique case (1'b1)
            (req_i == 2'b11): begin
                if (prio_q == SRC_ALU) begin
                    gnt_o[REQ_ALU] = 1'b1;
                end else begin
                    gnt_o[REQ_MEM] = 1'b1;
                end
            end
            (req_i == 2'b01): gnt_o[REQ_ALU] = 1'b1;
            (req_i == 2'b10): gnt_o[REQ_MEM] = 1'b1;
            default:          gnt_o = 2'b00;
        endcase
        // A grant is always an acceptance: ready goes nowhere else.
        if (gnt_o[REQ_ALU]) begin
            prio_d = other_src(SRC_ALU);
        end else if (gnt_o[REQ_MEM]) begin
            prio_d = other_src(SRC_MEM);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= SRC_ALU;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller: arbitrates ALU and load results into one
// register-file write port and tracks pending destinations.
module regfile_wb_ctrl
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT,
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int NREG   = NREG_DFLT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic [ADDR_W-1:0] chk_addr1,
    input  logic [ADDR_W-1:0] chk_addr2,
    output logic              hazard,
    output logic [ADDR_W-1:0] reg_write,
    output logic [DATA_W-1:0] wdata,
    output logic              write,
    output logic [NREG-1:0]   pending
);

    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              accept;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    logic              write_q;
    logic              write_d;
    logic [ADDR_W-1:0] reg_write_q;
    logic [ADDR_W-1:0] reg_write_d;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] wdata_d;
    logic [NREG-1:0]   pending_q;
    logic [NREG-1:0]   pending_d;

    assign req[REQ_ALU] = alu_valid;
    assign req[REQ_MEM] = mem_valid;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (req),
        .gnt_o (gnt)
    );

    assign alu_ready = gnt[REQ_ALU];
    assign mem_ready = gnt[REQ_MEM];
    assign accept    = |gnt;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        unique case (1'b1)
            gnt[REQ_ALU]: begin
                sel_addr = alu_addr;
                sel_data = alu_data;
            end
            gnt[REQ_MEM]: begin
                sel_addr = mem_addr;
                sel_data = mem_data;
            end
            default: begin
                sel_addr = '0;
                sel_data = '0;
            end
        endcase
    end

    always_comb begin
        write_d     = 1'b0;
        reg_write_d = reg_write_q;
        wdata_d     = wdata_q;
        if (accept) begin
            reg_write_d = sel_addr;
            wdata_d     = sel_data;
            write_d     = (sel_addr != '0);
        end
    end

    // Clear first so a reservation on the same edge wins.
    always_comb begin
        pending_d = pending_q;
        if (write_q) begin
            pending_d[reg_write_q] = 1'b0;
        end
        if (rsv_valid && (rsv_addr != '0)) begin
            pending_d[rsv_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q     <= 1'b0;
            reg_write_q <= '0;
            wdata_q     <= '0;
            pending_q   <= '0;
        end else begin
            write_q     <= write_d;
            reg_write_q <= reg_write_d;
            wdata_q     <= wdata_d;
            pending_q   <= pending_d;
        end
    end

    assign write     = write_q;
    assign reg_write = reg_write_q;
    assign wdata     = wdata_q;
    assign pending   = pending_q;
    assign hazard    = pending_q[chk_addr1] | pending_q[chk_addr2];

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed bench for regfile_wb_ctrl: arbitration, writeback latency,
// scoreboard set/clear and asynchronous reset.
module tb_regfile_wb_ctrl;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk;
    logic          rst_n;
    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;
    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          rsv_valid;
    logic [AW-1:0] rsv_addr;
    logic [AW-1:0] chk_addr1;
    logic [AW-1:0] chk_addr2;
    logic          hazard;
    logic [AW-1:0] reg_write;
    logic [DW-1:0] wdata;
    logic          write;
    logic [NR-1:0] pending;

    int n_chk;
    int n_fail;

    regfile_wb_ctrl #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .NREG   (NR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .chk_addr1 (chk_addr1),
        .chk_addr2 (chk_addr2),
        .hazard    (hazard),
        .reg_write (reg_write),
        .wdata     (wdata),
        .write     (write),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        alu_valid = 1'b0;
        alu_addr  = '0;
        alu_data  = '0;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_data  = '0;
        rsv_valid = 1'b0;
        rsv_addr  = '0;
        chk_addr1 = '0;
        chk_addr2 = '0;

        // Reset state and readies during reset
        #1;
        chk("rst_write", write, 0);
        chk("rst_reg_write", reg_write, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_pending", pending, 0);
        alu_valid = 1'b1;
        alu_addr  = 5'd7;
        alu_data  = 32'hDEAD;
        mem_valid = 1'b1;
        mem_addr  = 5'd6;
        #1;
        chk("rst_alu_ready", alu_ready, 1);
        chk("rst_mem_ready", mem_ready, 0);
        step();
        step();
        chk("rst_no_accept_write", write, 0);
        chk("rst_no_accept_wdata", wdata, 0);
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        rst_n     = 1'b1;
        #1;
        chk("idle_alu_ready", alu_ready, 0);
        chk("idle_mem_ready", mem_ready, 0);

        // Single ALU writeback, latency 1
        step();
        alu_valid = 1'b1;
        alu_addr  = 5'd8;
        alu_data  = 32'h0F;
        #1;
        chk("alu_ready", alu_ready, 1);
        chk("alu_mem_ready", mem_ready, 0);
        chk("alu_pre_write", write, 0);
        step();
        alu_valid = 1'b0;
        mem_valid = 1'b1;
        mem_addr  = 5'd0;
        mem_data  = 32'h7;
        #1;
        chk("alu_write", write, 1);
        chk("alu_reg_write", reg_write, 8);
        chk("alu_wdata", wdata, 32'h0F);
        chk("mem_ready", mem_ready, 1);
        chk("mem_alu_ready", alu_ready, 0);

        // Load to x0: index/data update but no write
        step();
        mem_valid = 1'b0;
        #1;
        chk("x0_write", write, 0);
        chk("x0_reg_write", reg_write, 0);
        chk("x0_wdata", wdata, 32'h7);
        step();
        #1;
        chk("hold_write", write, 0);
        chk("hold_reg_write", reg_write, 0);
        chk("hold_wdata", wdata, 32'h7);

        // Both valid for four cycles: ALU, MEM, ALU, MEM
        for (int i = 0; i < 4; i++) begin
            step();
            alu_valid = 1'b1;
            alu_addr  = 5'd3;
            alu_data  = 32'h100 + i;
            mem_valid = 1'b1;
            mem_addr  = 5'd5;
            mem_data  = 32'h200 + i;
            #1;
            chk($sformatf("rr_alu_ready%0d", i), alu_ready, (i % 2) == 0);
            chk($sformatf("rr_mem_ready%0d", i), mem_ready, (i % 2) == 1);
            if (i > 0) begin
                chk($sformatf("rr_write%0d", i), write, 1);
                chk($sformatf("rr_reg_write%0d", i), reg_write,
                    (i % 2) == 1 ? 3 : 5);
                chk($sformatf("rr_wdata%0d", i), wdata,
                    (i % 2) == 1 ? 32'h100 + i - 1 : 32'h200 + i - 1);
            end
        end
        step();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        #1;
        chk("rr_last_write", write, 1);
        chk("rr_last_reg_write", reg_write, 5);
        chk("rr_last_wdata", wdata, 32'h203);
        chk("rr_pending_clean", pending, 0);

        // Reservation of x3 and hazard until commit
        step();
        rsv_valid = 1'b1;
        rsv_addr  = 5'd3;
        chk_addr1 = 5'd3;
        chk_addr2 = 5'd0;
        #1;
        chk("rsv_hazard_pre", hazard, 0);
        step();
        rsv_valid = 1'b0;
        #1;
        chk("rsv_pending", pending, 32'h8);
        chk("rsv_hazard", hazard, 1);
        step();
        alu_valid = 1'b1;
        alu_addr  = 5'd3;
        alu_data  = 32'hAA;
        #1;
        chk("rsv_hazard_req", hazard, 1);
        step();
        alu_valid = 1'b0;
        #1;
        chk("rsv_commit_write", write, 1);
        chk("rsv_hazard_wcyc", hazard, 1);
        step();
        #1;
        chk("rsv_hazard_clear", hazard, 0);
        chk("rsv_pending_clear", pending, 0);

        // Reservation of x0 ignored; hazard via second source
        rsv_valid = 1'b1;
        rsv_addr  = 5'd0;
        step();
        rsv_valid = 1'b0;
        chk_addr1 = 5'd0;
        #1;
        chk("rsv0_pending", pending, 0);
        chk("rsv0_hazard", hazard, 0);

        // Set and clear of x4 on the same edge: set wins
        step();
        alu_valid = 1'b1;
        alu_addr  = 5'd4;
        alu_data  = 32'h44;
        step();
        alu_valid = 1'b0;
        rsv_valid = 1'b1;
        rsv_addr  = 5'd4;
        chk_addr2 = 5'd4;
        #1;
        chk("sw_write", write, 1);
        chk("sw_reg_write", reg_write, 4);
        step();
        rsv_valid = 1'b0;
        #1;
        chk("sw_pending", pending, 32'h10);
        chk("sw_hazard2", hazard, 1);

        // Reset asserted while a write is in flight
        alu_valid = 1'b1;
        alu_addr  = 5'd9;
        alu_data  = 32'h55;
        @(posedge clk);
        #1;
        chk("mid_write_before", write, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_write", write, 0);
        chk("mid_rst_pending", pending, 0);
        chk("mid_rst_wdata", wdata, 0);
        chk("mid_rst_hazard", hazard, 0);
        step();
        chk("mid_rst_alu_ready", alu_ready, 1);
        alu_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        #1;
        chk("post_rst_write", write, 0);
        chk("post_rst_reg_write", reg_write, 0);
        chk("post_rst_pending", pending, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule

// File: doc/regfile_wb_ctrl.md
REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

Interface
REQ-001 Parameters SHALL be: DATA_W, 32, data width; ADDR_W, 5, register index width; NREG, 32, register count (2**ADDR_W).
REQ-002 Ports SHALL be, clock and reset first:
  clk  in  1  single clock, all state on rising edge
  rst_n  in  1  reset, asynchronous, active-low
  alu_valid  in  1  ALU writeback request
  alu_ready  out  1  ALU request accepted this cycle
  alu_addr  in  ADDR_W  ALU destination register
  alu_data  in  DATA_W  ALU result
  mem_valid  in  1  load writeback request
  mem_ready  out  1  load request accepted this cycle
  mem_addr  in  ADDR_W  load destination register
  mem_data  in  DATA_W  load data
  rsv_valid  in  1  issue stage reserves a destination
  rsv_addr  in  ADDR_W  reserved register
  chk_addr1  in  ADDR_W  source register 1 to check
  chk_addr2  in  ADDR_W  source register 2 to check
  hazard  out  1  either checked source is pending
  reg_write  out  ADDR_W  register-file write index
  wdata  out  DATA_W  register-file write data
  write  out  1  register-file write enable
  pending  out  NREG  scoreboard bit vector

Function
REQ-003 At most one request SHALL be accepted per cycle; a request is accepted when valid and ready are both 1 at a rising edge.
REQ-004 With exactly one valid requester, that requester's ready SHALL be 1 combinationally.
REQ-005 With both valid, ready SHALL go to the requester not granted most recently (round-robin); the other ready SHALL be 0.
REQ-006 With no valid requester, both readies SHALL be 0 and the round-robin pointer SHALL hold.
REQ-007 Ready SHALL never depend on write, hazard or pending (no back-pressure from the register file).
REQ-008 Accepted request at edge k: reg_write and wdata SHALL take its addr/data, and write SHALL be 1 during cycle k+1 (latency 1).
REQ-009 Accepted request to register 0: write SHALL be 0 in cycle k+1; reg_write/wdata still update.
REQ-010 Cycles with no acceptance: write SHALL be 0; reg_write and wdata SHALL hold.
REQ-011 rsv_valid=1 with rsv_addr!=0 SHALL set pending[rsv_addr] at the edge; rsv_addr=0 SHALL be ignored; pending[0] SHALL always be 0.
REQ-012 pending[reg_write] SHALL clear at the edge ending a cycle where write=1 (same edge the register file commits).
REQ-013 Set and clear of the same bit at one edge: set SHALL win (bit stays 1).
REQ-014 A commit to a non-pending register SHALL leave pending unchanged and is legal.
REQ-015 hazard SHALL equal pending[chk_addr1] | pending[chk_addr2], combinational, no bypass from in-flight writes.

Reset
REQ-016 rst_n=0 SHALL asynchronously force write=0, reg_write=0, wdata=0, pending=0 and the pointer to favour ALU first.
REQ-017 Requests in flight when reset asserts SHALL be discarded; no write SHALL issue after release for them.
REQ-018 During reset, readies SHALL still follow REQ-004/005 combinationally, but no acceptance SHALL take effect.

Structure
REQ-019 DATA_W, ADDR_W, NREG defaults and requester index constants (REQ_ALU=0, REQ_MEM=1) SHALL live in shared package regfile_pkg.
REQ-020 The two-way round-robin grant and last-grant flop SHALL be sub-module rr_arb2; scoreboard and output register SHALL be in regfile_wb_ctrl.

Verification
REQ-021 Reset release, alu_valid=1 addr=8 data=0x0F -> alu_ready=1; next cycle write=1, reg_write=8, wdata=0x0F.
REQ-022 Both valid 4 cycles (alu addr=3, mem addr=5) -> grants alternate ALU,MEM,ALU,MEM; write=1 each following cycle.
REQ-023 mem_valid=1 addr=0 data=0x7 -> mem_ready=1; next cycle write=0, reg_write=0.
REQ-024 rsv addr=3; chk_addr1=3 -> hazard=1; ALU writes 3 -> hazard=1 through write cycle, 0 the cycle after.
REQ-025 rsv addr=4 same edge as commit to 4 -> pending[4]=1 afterwards; rst_n pulsed low mid-stream -> write=0, pending=0 immediately.
